// File: rtl/regfile_ctx_engine.sv
// Register-file context save/restore engine: walks registers FIRST_REG..LAST_REG,
// dumping them to memory at a latched base address or reloading them from it.
//
// state | meaning
// IDLE  | waiting for start_save / start_restore
// SAVE  | read reg r via rsel1 and write it to memory until mem_ack
// RLOAD | read the word for reg r from memory until mem_ack
// RWB   | write the captured word into reg r for one cycle
// FIN   | one-cycle done pulse, starts ignored
module regfile_ctx_engine #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start_save,
  input  logic        start_restore,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store,
  input  logic [31:0] mem_load,
  input  logic        mem_ack,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  output logic [4:0]  rsel1,
  output logic [4:0]  rsel2,
  input  logic [31:0] rdat1,
  input  logic [31:0] rdat2
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {IDLE, SAVE, RLOAD, RWB, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  r_q, r_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic [31:0] offset;
  logic        unused_rdat2;

  assign unused_rdat2 = ^rdat2;
  assign rsel2        = 5'd0;

  // Word offset of the current register from the base; the add wraps mod 2^32.
  assign offset = {27'd0, r_q - FIRST_IDX} << 2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      r_q     <= FIRST_IDX;
      base_q  <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    base_d    = base_q;
    data_d    = data_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'd0;
    mem_store = 32'd0;
    WEN       = 1'b0;
    wsel      = 5'd0;
    wdat      = 32'd0;
    rsel1     = 5'd0;
    case (state_q)
      IDLE: begin
        if (start_save) begin
          state_d = SAVE;
          base_d  = base_addr;
          r_d     = FIRST_IDX;
        end else if (start_restore) begin
          state_d = RLOAD;
          base_d  = base_addr;
          r_d     = FIRST_IDX;
        end
      end
      SAVE: begin
        busy      = 1'b1;
        rsel1     = r_q;
        mem_wen   = 1'b1;
        mem_store = rdat1;
        mem_addr  = base_q + offset;
        if (mem_ack) begin
          if (r_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            r_d = r_q + 5'd1;
          end
        end
      end
      RLOAD: begin
        busy     = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = base_q + offset;
        if (mem_ack) begin
          data_d  = mem_load;
          state_d = RWB;
        end
      end
      RWB: begin
        busy = 1'b1;
        WEN  = 1'b1;
        wsel = r_q;
        wdat = data_q;
        if (r_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          r_d     = r_q + 5'd1;
          state_d = RLOAD;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Bench for regfile_ctx_engine: register-file and memory models around the DUT,
// directed and randomized save/restore runs checked against an arithmetic model.
module tb_regfile_ctx_engine;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start_save, start_restore;
  logic [31:0] base_addr;
  logic        busy, done, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_store, mem_load;
  logic        mem_ack;
  logic        WEN;
  logic [4:0]  wsel, rsel1, rsel2;
  logic [31:0] wdat, rdat1, rdat2;

  regfile_ctx_engine dut (
    .CLK(CLK), .nRST(nRST), .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load), .mem_ack(mem_ack),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel1(rsel1), .rsel2(rsel2),
    .rdat1(rdat1), .rdat2(rdat2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register file model (not reset, so writes survive a DUT reset).
  logic [31:0] regs [32];
  logic [31:0] pl_vals [32];
  logic        pl_go;
  always @(posedge CLK) begin
    if (pl_go) begin
      for (int i = 0; i < 32; i++) regs[i] <= pl_vals[i];
    end else if (WEN) begin
      regs[wsel] <= wdat;
    end
  end
  assign rdat1 = regs[rsel1];
  assign rdat2 = 32'hDEAD_BEEF;

  // Memory model: 32 words at mem_base_tb, mem_ack after wait_n stall cycles.
  logic [31:0] mem [32];
  logic [31:0] mem_base_tb, mem_off;
  int          wait_n, wcnt = 0;
  assign mem_off  = mem_addr - mem_base_tb;
  assign mem_load = (mem_ren && mem_ack) ? mem[mem_off[6:2]] : 32'd0;
  assign mem_ack  = (mem_ren || mem_wen) && (wcnt >= wait_n);
  always @(posedge CLK) begin
    if (!(mem_ren || mem_wen) || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Monitor: samples mid-cycle, i.e. the values presented to the next rising edge.
  logic [63:0] wr_log [$];
  logic [31:0] rd_log [$];
  logic [36:0] wen_log [$];
  int done_cnt = 0, busy_cnt = 0, ren_cnt = 0, req_cnt = 0, both_cnt = 0, unstable_cnt = 0;
  logic        pend_q = 1'b0;
  logic [65:0] pend_snap = '0;
  always @(negedge CLK) begin
    if (mem_wen && mem_ack) wr_log.push_back({mem_addr, mem_store});
    if (mem_ren && mem_ack) rd_log.push_back(mem_addr);
    if (WEN) wen_log.push_back({wsel, wdat});
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_ren || mem_wen) req_cnt <= req_cnt + 1;
    if (mem_ren && mem_wen) both_cnt <= both_cnt + 1;
    if (pend_q && ({mem_ren, mem_wen, mem_addr, mem_store} !== pend_snap))
      unstable_cnt <= unstable_cnt + 1;
    pend_q    <= (mem_ren || mem_wen) && !mem_ack;
    pend_snap <= {mem_ren, mem_wen, mem_addr, mem_store};
  end

  int n_pass = 0, n_total = 0;
  logic [31:0] exp_regs [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, mem_ren, mem_wen, WEN}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, {mem_store, wdat}, 0);
    chk({tag, "_sel"}, {wsel, rsel1, rsel2}, 0);
  endtask

  task automatic preload_regs();
    exp_regs[0] = 32'd0;
    for (int i = 0; i < 32; i++) pl_vals[i] = exp_regs[i];
    @(negedge CLK); pl_go = 1'b1;
    @(negedge CLK); pl_go = 1'b0;
  endtask

  // Issues a start, optionally pokes starts while busy / in FIN, returns cycles to done.
  task automatic run_op(input bit sv, input bit rs, input logic [31:0] base,
                        input int poke_at, input bit fin_poke, output int lat);
    int c0;
    lat = -1;
    @(negedge CLK);
    start_save = sv; start_restore = rs; base_addr = base;
    @(posedge CLK); #1;
    c0 = cyc;
    start_save = 1'b0; start_restore = 1'b0; base_addr = $urandom;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK); #1;
      if (k == poke_at) begin start_save = 1'b1; start_restore = 1'b1; end
      else begin start_save = 1'b0; start_restore = 1'b0; end
      if (done) begin lat = cyc - c0 + 1; break; end
    end
    chk("op_completes", lat > 0, 1);
    if (fin_poke) begin
      start_save = 1'b1; start_restore = 1'b1;
    end
    @(posedge CLK); #1;
    start_save = 1'b0; start_restore = 1'b0;
  endtask

  task automatic check_save(input string tag, input logic [31:0] base, input int w0);
    int n;
    n = wr_log.size() - w0;
    chk({tag, "_nwr"}, n, 31);
    if (n > 31) n = 31;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_log[w0 + i], {base + 32'(4 * i), exp_regs[i + 1]});
  endtask

  task automatic check_restore(input string tag, input int e0, input int upto);
    int n;
    n = wen_log.size() - e0;
    chk({tag, "_nwen"}, n, upto);
    if (n > upto) n = upto;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wen%0d", tag, i), wen_log[e0 + i], {5'(i + 1), mem[i]});
    for (int r = 1; r < 32; r++)
      chk($sformatf("%s_reg%0d", tag, r), regs[r], (r <= upto) ? mem[r - 1] : exp_regs[r]);
    chk({tag, "_reg0"}, regs[0], 0);
  endtask

  initial begin
    int lat, w0, e0, b0, r0, d0, q0, w;
    logic [31:0] base;
    nRST = 1'b0; start_save = 1'b0; start_restore = 1'b0; base_addr = 32'd0;
    pl_go = 1'b0; wait_n = 0; mem_base_tb = 32'd0;
    for (int i = 0; i < 32; i++) begin pl_vals[i] = 32'd0; mem[i] = 32'd0; exp_regs[i] = 32'd0; end

    // Reset held with starts toggling.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      start_save = c[0]; start_restore = ~c[0]; base_addr = $urandom;
      #1 chk_outputs_zero($sformatf("rst%0d", c));
    end
    @(negedge CLK); start_save = 1'b0; start_restore = 1'b0; nRST = 1'b1;
    r0 = req_cnt; b0 = busy_cnt;
    repeat (5) @(negedge CLK);
    #1 chk("post_rst_req", req_cnt - r0, 0);
    chk("post_rst_busy", busy_cnt - b0, 0);

    // Save, zero wait.
    for (int i = 1; i < 32; i++) exp_regs[i] = 32'hA5A5_0000 + 32'(i);
    preload_regs();
    wait_n = 0; w0 = wr_log.size(); b0 = busy_cnt; d0 = done_cnt; q0 = ren_cnt;
    run_op(1'b1, 1'b0, 32'h1000, -1, 1'b0, lat);
    chk("save_lat", lat, 32);
    chk("save_busy", busy_cnt - b0, 31);
    chk("save_done", done_cnt - d0, 1);
    chk("save_noren", ren_cnt - q0, 0);
    check_save("save", 32'h1000, w0);

    // Restore with two stall cycles per read.
    for (int k = 0; k < 32; k++) mem[k] = 32'hC0DE_0000 + 32'(k);
    for (int i = 1; i < 32; i++) exp_regs[i] = 32'h1111_0000 + 32'(i);
    preload_regs();
    mem_base_tb = 32'h2000; wait_n = 2; e0 = wen_log.size(); b0 = busy_cnt; r0 = rd_log.size();
    run_op(1'b0, 1'b1, 32'h2000, -1, 1'b0, lat);
    chk("rest_lat", lat, 31 * 4 + 1);
    chk("rest_busy", busy_cnt - b0, 31 * 4);
    chk("rest_nrd", rd_log.size() - r0, 31);
    if (rd_log.size() - r0 >= 31) chk("rest_rd_last", rd_log[r0 + 30], 32'h2000 + 32'd120);
    check_restore("rest", e0, 31);

    // Both starts at once, starts poked while busy and in FIN.
    for (int i = 1; i < 32; i++) exp_regs[i] = $urandom;
    preload_regs();
    wait_n = 0; base = $urandom; w0 = wr_log.size(); d0 = done_cnt; q0 = ren_cnt;
    run_op(1'b1, 1'b1, base, 5, 1'b1, lat);
    chk("both_lat", lat, 32);
    b0 = busy_cnt; w = wr_log.size();
    repeat (4) @(negedge CLK);
    #1 chk("both_done", done_cnt - d0, 1);
    chk("both_noren", ren_cnt - q0, 0);
    chk("fin_poke_busy", busy_cnt - b0, 0);
    chk("fin_poke_nwr", wr_log.size() - w, 0);
    check_save("both", base, w0);

    // Randomized save across the 32-bit wrap with random stalls.
    for (int i = 1; i < 32; i++) exp_regs[i] = $urandom;
    preload_regs();
    wait_n = $urandom_range(0, 3); w0 = wr_log.size(); b0 = busy_cnt;
    run_op(1'b1, 1'b0, 32'hFFFF_FFF8, -1, 1'b0, lat);
    chk("wrap_lat", lat, 31 * (wait_n + 1) + 1);
    chk("wrap_busy", busy_cnt - b0, 31 * (wait_n + 1));
    if (wr_log.size() - w0 >= 3) chk("wrap_a2", wr_log[w0 + 2][63:32], 32'h0);
    check_save("wrap", 32'hFFFF_FFF8, w0);

    // Randomized restore, random base and stalls.
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    for (int i = 1; i < 32; i++) exp_regs[i] = $urandom;
    preload_regs();
    base = $urandom; mem_base_tb = base; wait_n = $urandom_range(0, 3); e0 = wen_log.size();
    run_op(1'b0, 1'b1, base, -1, 1'b0, lat);
    chk("rrest_lat", lat, 31 * (wait_n + 2) + 1);
    check_restore("rrest", e0, 31);

    // Reset in the middle of a restore, right after register 10 is written.
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    for (int i = 1; i < 32; i++) exp_regs[i] = 32'h5EED_0000 + 32'(i);
    preload_regs();
    base = $urandom; mem_base_tb = base; wait_n = 0; e0 = wen_log.size(); lat = -1;
    @(negedge CLK); start_restore = 1'b1; base_addr = base;
    @(negedge CLK); start_restore = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge CLK); #1;
      if (wen_log.size() - e0 >= 10) begin lat = k; break; end
    end
    chk("mid_reach10", lat >= 0, 1);
    nRST = 1'b0;
    #1 chk_outputs_zero("mid_rst_a");
    repeat (2) @(negedge CLK);
    chk_outputs_zero("mid_rst_b");
    @(negedge CLK); nRST = 1'b1;
    r0 = req_cnt; w = wen_log.size(); b0 = busy_cnt;
    repeat (10) @(negedge CLK);
    #1 chk("mid_post_req", req_cnt - r0, 0);
    chk("mid_post_wen", wen_log.size() - w, 0);
    chk("mid_post_busy", busy_cnt - b0, 0);
    check_restore("mid", e0, 10);

    chk("never_ren_wen", both_cnt, 0);
    chk("req_stable", unstable_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_ctx_engine.md
# regfile_ctx_engine

Context save/restore engine that sits on the initiator side of the register file interface. On command it walks architectural registers 1–31, either reading each one and writing it to memory at a base address (save), or reading memory and writing each word back into the register file (restore). It is used for core context switches and for loading and dumping register state in the testbench.

## Interface
Parameters:
- FIRST_REG, 1, first register index processed; register 0 is never written.
- LAST_REG, 31, last register index processed; FIRST_REG ≤ LAST_REG ≤ 31.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start_save  in  1  one-cycle request to start a save.
- start_restore  in  1  one-cycle request to start a restore.
- base_addr  in  32  memory base address, sampled on an accepted start.
- busy  out  1  high while a save or restore is in progress.
- done  out  1  one-cycle pulse when an operation completes.
- mem_ren  out  1  memory read request.
- mem_wen  out  1  memory write request.
- mem_addr  out  32  memory word address.
- mem_store  out  32  write data (word_t).
- mem_load  in  32  read data, valid when mem_ack is high during a read.
- mem_ack  in  1  transfer complete; may be high in the same cycle as the request.
- WEN  out  1  register file write enable.
- wsel  out  5  write select (regbits_t).
- wdat  out  32  write data (word_t).
- rsel1  out  5  read select.
- rsel2  out  5  tied to 0.
- rdat1  in  32  combinational read data for rsel1.
- rdat2  in  32  unused.

## Operation
- States: IDLE, SAVE, RLOAD, RWB, FIN.
- IDLE:
  - start_save → SAVE.
  - start_restore → RLOAD.
  - If both are high in the same cycle, save wins and the restore request is dropped.
  - Any accepted start latches base_addr and sets the index r = FIRST_REG.
  - Starts are ignored in every state except IDLE.
- SAVE:
  - rsel1 = r, mem_wen = 1, mem_store = rdat1, mem_addr = base + 4·(r−FIRST_REG).
  - Request and address are held stable until mem_ack.
  - On mem_ack: if r = LAST_REG go to FIN, else r+1 and stay in SAVE.
- RLOAD:
  - mem_ren = 1, mem_addr as in SAVE.
  - On mem_ack: capture mem_load into a data register and go to RWB.
- RWB:
  - WEN = 1, wsel = r, wdat = captured word, for exactly one cycle.
  - Then: if r = LAST_REG go to FIN, else r+1 and go to RLOAD.
- FIN:
  - done = 1 for one cycle, then IDLE.
- Exclusivity and defaults:
  - mem_ren and mem_wen are never high together.
  - WEN is high only in RWB.
  - rsel1 = 0 outside SAVE.
- Address arithmetic is 32-bit modulo 2^32, so wrap-around is permitted and silent.
- busy = 1 in SAVE, RLOAD and RWB; busy = 0 in IDLE and FIN.

## Timing
- Reset (asynchronous, nRST low): state IDLE, r = FIRST_REG. All outputs 0: busy, done, mem_ren, mem_wen, mem_addr, mem_store, WEN, wsel, wdat, rsel1, rsel2.
- Reset asserted mid-operation: no further WEN or memory request is issued after reset is released. Registers already written stay written.
- Start is accepted at a rising edge. Requests begin the following cycle.
- Save, ack in the same cycle as each request: N = LAST_REG−FIRST_REG+1 cycles of SAVE, then 1 FIN cycle. Default is 31 + 1.
- Restore, zero-wait memory: 2 cycles per register (RLOAD, RWB) plus FIN. Default is 62 + 1.
- Each cycle of mem_ack low adds one cycle and holds all outputs constant.
- A start asserted in the FIN cycle is ignored.

## Test plan
- Reset: hold nRST low for 3 cycles with starts toggling → every output is 0 and state is IDLE. Deassert nRST → no request issued.
- Save, zero wait: registers preloaded with reg[i] = 0xA5A50000+i, base = 0x1000 → 31 writes; the write to 0x1000+4(i−1) carries 0xA5A50000+i. done pulses at cycle 32 after start; busy is high for 31 cycles.
- Restore with wait states: memory word k = 0xC0DE0000+k, mem_ack delayed 2 cycles per read → reg[k+1] = 0xC0DE0000+k. WEN is high exactly 31 times, never for register 0. Total time 31·4 + 1 cycles.
- Simultaneous start_save and start_restore in IDLE → save runs and no mem_ren is seen. A start pulsed while busy is ignored: exactly one done.
- Wrap-around: base = 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, and so on.
- Reset in restore after register 10 → registers 1–10 updated, registers 11–31 untouched. All outputs 0 during reset.
